mem_stage_ctrl: RTL and testbench

- Memory stage of the pipelined core; consumes the E/M pipeline register outputs and drives the data memory over a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the M/W pipeline register.
- Exports the forwarding sources (ALUResultMFB, ResultW) consumed by the execute-stage forwarding muxes.

---
 rtl/mem_stage_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage: E/M to data memory req/ack, M/W register, forwarding; optional MEM_TIMEOUT_EN abort
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int WA_W    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [WA_W-1:0]   WA3M,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUResultMFB,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [WA_W-1:0]   WA3W,
    output logic [DATA_W-1:0] ResultW,
    output logic              MemErrW
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {W_PASS, W_BUBBLE, W_ACK, W_ABORT} wmode_t;

    state_t              state, state_nx;
    wmode_t              wmode;
    logic                acc;
    logic                timeout;
    logic                req_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    assign acc          = MemWriteM | MemtoRegM;
    assign ALUResultMFB = ALUResultM;
    assign MemReq       = req_q;
    assign MemWe        = we_q;
    assign MemAddr      = addr_q;
    assign MemWData     = wdata_q;
    assign ResultW      = MemtoRegW ? ReadDataW : ALUOutW;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count BUSY cycles without an ack; cleared while idle so each access starts at zero
    always_ff @(posedge clk) begin
        if (reset || state == IDLE)
            wait_cnt <= '0;
        else if (!MemAck)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Abort on the TIMEOUT-th unacknowledged BUSY cycle; an ack in the same cycle wins
    assign timeout = (state == BUSY) && !MemAck && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    // No abort path: BUSY waits for the ack indefinitely
    assign timeout = (TIMEOUT < 0);
`endif

    // Next state, upstream stall and the kind of entry the M/W register takes this edge
    always_comb begin
        state_nx = state;
        StallM   = 1'b0;
        wmode    = W_PASS;
        case (state)
            IDLE: begin
                if (acc) begin
                    StallM   = 1'b1;
                    state_nx = BUSY;
                    wmode    = W_BUBBLE;
                end
            end
            BUSY: begin
                if (MemAck) begin
                    state_nx = IDLE;
                    wmode    = W_ACK;
                end else if (timeout) begin
                    state_nx = IDLE;
                    wmode    = W_ABORT;
                end else begin
                    StallM   = 1'b1;
                    wmode    = W_BUBBLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, registered request and the access latches captured when an access is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            req_q <= (state_nx == BUSY);
            if (state == IDLE && acc) begin
                we_q    <= MemWriteM;
                addr_q  <= ALUResultM;
                wdata_q <= WriteDataM;
            end
        end
    end

    // M/W pipeline register: pass-through, bubble, completed access or aborted access
    always_ff @(posedge clk) begin
        if (reset) begin
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            WA3W      <= '0;
            MemErrW   <= 1'b0;
        end else begin
            case (wmode)
                W_BUBBLE: begin
                    PCSrcW    <= 1'b0;
                    RegWriteW <= 1'b0;
                    MemtoRegW <= 1'b0;
                    ALUOutW   <= '0;
                    ReadDataW <= '0;
                    WA3W      <= '0;
                    MemErrW   <= 1'b0;
                end
                W_ACK: begin
                    PCSrcW    <= PCSrcM;
                    RegWriteW <= RegWriteM;
                    MemtoRegW <= MemtoRegM & ~MemWriteM;
                    ALUOutW   <= ALUResultM;
                    ReadDataW <= MemRData;
                    WA3W      <= WA3M;
                    MemErrW   <= 1'b0;
                end
                W_ABORT: begin
                    PCSrcW    <= PCSrcM;
                    RegWriteW <= 1'b0;
                    MemtoRegW <= MemtoRegM & ~MemWriteM;
                    ALUOutW   <= ALUResultM;
                    ReadDataW <= '0;
                    WA3W      <= WA3M;
                    MemErrW   <= 1'b1;
                end
                default: begin
                    PCSrcW    <= PCSrcM;
                    RegWriteW <= RegWriteM;
                    MemtoRegW <= MemtoRegM & ~MemWriteM;
                    ALUOutW   <= ALUResultM;
                    ReadDataW <= '0;
                    WA3W      <= WA3M;
                    MemErrW   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  WA3M;
    logic        MemReq, MemWe, MemAck;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        StallM;
    logic [31:0] ALUResultMFB;
    logic        PCSrcW, RegWriteW, MemtoRegW, MemErrW;
    logic [31:0] ALUOutW, ReadDataW, ResultW;
    logic [2:0]  WA3W;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_W(32), .WA_W(3), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData), .StallM(StallM), .ALUResultMFB(ALUResultMFB),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WA3W(WA3W), .ResultW(ResultW),
        .MemErrW(MemErrW)
    );

    // Instruction as presented by the E/M register, plus memory behaviour and literal stall count
    typedef struct {
        logic        pcsrc, regw, memw, memtoreg, stray_ack;
        logic [31:0] alu, wd, rdata;
        logic [2:0]  wa;
        int          delay;
        int          stalls;
    } instr_t;

    // One clock cycle of the expected timeline
    typedef struct {
        int          idx;
        logic        ack;
        logic [31:0] rdata;
        logic        stall, req, bubble;
    } cyc_t;

    localparam int NPROG = 8;
    instr_t      prog [NPROG];
    cyc_t        tab  [64];
    int          ncyc;
    int          cyc;
    bit          run = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stall_obs [NPROG];
    logic [31:0] res_seen  [NPROG];
    int          req_pulses = 0;
    logic        prev_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic pcsrc, regw, memw, memtoreg, stray,
                                  input logic [31:0] alu, wd, rdata, input logic [2:0] wa,
                                  input int delay, input int stalls);
        instr_t t;
        t.pcsrc = pcsrc; t.regw = regw; t.memw = memw; t.memtoreg = memtoreg; t.stray_ack = stray;
        t.alu = alu; t.wd = wd; t.rdata = rdata; t.wa = wa; t.delay = delay; t.stalls = stalls;
        return t;
    endfunction

    task automatic drive(input instr_t t);
        PCSrcM = t.pcsrc; RegWriteM = t.regw; MemWriteM = t.memw; MemtoRegM = t.memtoreg;
        ALUResultM = t.alu; WriteDataM = t.wd; WA3M = t.wa;
    endtask

    // Timeline from the stage's rules: a memory op stalls 1 + ack-delay cycles, emitting a bubble per stall
    task automatic build();
        ncyc = 0;
        for (int i = 0; i < NPROG; i++) begin
            if (prog[i].memw || prog[i].memtoreg) begin
                tab[ncyc] = '{i, prog[i].stray_ack, 32'hBAD0_0000 + 32'(ncyc), 1'b1, 1'b0, 1'b1};
                ncyc++;
                for (int j = 0; j < prog[i].delay; j++) begin
                    tab[ncyc] = '{i, 1'b0, 32'hBAD0_0000 + 32'(ncyc), 1'b1, 1'b1, 1'b1};
                    ncyc++;
                end
                tab[ncyc] = '{i, 1'b1, prog[i].rdata, 1'b0, 1'b1, 1'b0};
                ncyc++;
            end else begin
                tab[ncyc] = '{i, prog[i].stray_ack, 32'hBAD0_0000 + 32'(ncyc), 1'b0, 1'b0, 1'b0};
                ncyc++;
            end
        end
    endtask

    // Per-cycle comparison of the DUT against the timeline
    always @(negedge clk) begin
        if (run) begin
            cyc_t   c;
            instr_t p;
            c = tab[cyc];
            p = prog[c.idx];
            chk("StallM", 32'(StallM), 32'(c.stall));
            chk("MemReq", 32'(MemReq), 32'(c.req));
            chk("ALUResultMFB", ALUResultMFB, p.alu);
            if (c.req) begin
                chk("MemWe", 32'(MemWe), 32'(p.memw));
                chk("MemAddr", MemAddr, p.alu);
                if (p.memw) chk("MemWData", MemWData, p.wd);
            end
            if (StallM) stall_obs[c.idx]++;
            if (MemReq && !prev_req) req_pulses++;
            prev_req = MemReq;
            if (cyc == 0) begin
                chk("reset RegWriteW", 32'(RegWriteW), 32'h0);
                chk("reset PCSrcW", 32'(PCSrcW), 32'h0);
                chk("reset ALUOutW", ALUOutW, 32'h0);
                chk("reset ReadDataW", ReadDataW, 32'h0);
                chk("reset WA3W", 32'(WA3W), 32'h0);
            end else begin
                cyc_t        q;
                instr_t      w;
                logic [31:0] rd;
                logic        m2r;
                q = tab[cyc-1];
                w = prog[q.idx];
                chk("MemErrW", 32'(MemErrW), 32'h0);
                if (q.bubble) begin
                    chk("bubble RegWriteW", 32'(RegWriteW), 32'h0);
                    chk("bubble PCSrcW", 32'(PCSrcW), 32'h0);
                    chk("bubble MemtoRegW", 32'(MemtoRegW), 32'h0);
                end else begin
                    rd  = (w.memw || w.memtoreg) ? q.rdata : 32'h0;
                    m2r = w.memtoreg && !w.memw;
                    chk("RegWriteW", 32'(RegWriteW), 32'(w.regw));
                    chk("PCSrcW", 32'(PCSrcW), 32'(w.pcsrc));
                    chk("MemtoRegW", 32'(MemtoRegW), 32'(m2r));
                    chk("ALUOutW", ALUOutW, w.alu);
                    chk("ReadDataW", ReadDataW, rd);
                    chk("WA3W", 32'(WA3W), 32'(w.wa));
                    chk("ResultW", ResultW, m2r ? rd : w.alu);
                    res_seen[q.idx] = ResultW;
                end
            end
        end
    end

    initial begin
        instr_t nop;
        nop = mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0);
        prog[0] = mk(0, 1, 0, 0, 1, 32'h0000_0042, 32'h0, 32'h0, 3'd5, 0, 0);
        prog[1] = mk(0, 0, 1, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_5555, 3'd1, 0, 1);
        prog[2] = mk(0, 1, 0, 1, 1, 32'h0000_0200, 32'h0, 32'h0000_1234, 3'd2, 3, 4);
        prog[3] = mk(0, 1, 0, 1, 0, 32'h0000_0010, 32'h0, 32'hAAAA_0010, 3'd3, 0, 1);
        prog[4] = mk(0, 1, 0, 1, 0, 32'h0000_0014, 32'h0, 32'hBBBB_0014, 3'd4, 0, 1);
        prog[5] = mk(1, 0, 0, 0, 0, 32'h0000_0007, 32'h0, 32'h0, 3'd7, 0, 0);
        prog[6] = nop;
        prog[7] = nop;
        for (int i = 0; i < NPROG; i++) begin stall_obs[i] = 0; res_seen[i] = 32'h0; end
        build();

        reset = 1'b1; MemAck = 1'b0; MemRData = 32'h0; drive(nop);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            cyc = k;
            drive(prog[tab[k].idx]);
            MemAck = tab[k].ack;
            MemRData = tab[k].rdata;
            run = 1'b1;
        end
        @(posedge clk); #1;
        run = 1'b0;
        MemAck = 1'b0;

        // Hand-computed pins on the timeline
        for (int i = 0; i < 6; i++) chk($sformatf("stall count instr %0d", i), 32'(stall_obs[i]), 32'(prog[i].stalls));
        chk("request pulses", 32'(req_pulses), 32'd4);
        chk("ALU ResultW", res_seen[0], 32'h0000_0042);
        chk("load ResultW", res_seen[2], 32'h0000_1234);
        chk("b2b load 1 ResultW", res_seen[3], 32'hAAAA_0010);
        chk("b2b load 2 ResultW", res_seen[4], 32'hBBBB_0014);

        // Reset while BUSY, then a late ack
        drive(mk(0, 1, 0, 1, 0, 32'h0000_0300, 32'h0, 32'h0, 3'd6, 0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy before reset MemReq", 32'(MemReq), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(nop);
        MemAck = 1'b1;
        MemRData = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("after reset MemReq", 32'(MemReq), 32'h0);
        chk("after reset StallM", 32'(StallM), 32'h0);
        chk("after reset RegWriteW", 32'(RegWriteW), 32'h0);
        chk("after reset ALUOutW", ALUOutW, 32'h0);
        chk("after reset WA3W", 32'(WA3W), 32'h0);
        @(posedge clk); #1;
        MemAck = 1'b0;
        @(negedge clk);
        chk("late ack MemReq", 32'(MemReq), 32'h0);
        chk("late ack ReadDataW", ReadDataW, 32'h0);
        chk("late ack RegWriteW", 32'(RegWriteW), 32'h0);

`ifdef MEM_TIMEOUT_EN
        // Load never acked: abort on the 4th BUSY cycle
        drive(mk(0, 1, 0, 1, 0, 32'h0000_0400, 32'h0, 32'h0, 3'd3, 0, 0));
        @(negedge clk);
        chk("to idle StallM", 32'(StallM), 32'h1);
        for (int b = 1; b <= 4; b++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("to busy%0d MemReq", b), 32'(MemReq), 32'h1);
            chk($sformatf("to busy%0d StallM", b), 32'(StallM), (b == 4) ? 32'h0 : 32'h1);
            chk($sformatf("to busy%0d MemErrW", b), 32'(MemErrW), 32'h0);
        end
        @(posedge clk); #1;
        drive(nop);
        @(negedge clk);
        chk("abort MemErrW", 32'(MemErrW), 32'h1);
        chk("abort RegWriteW", 32'(RegWriteW), 32'h0);
        chk("abort ReadDataW", ReadDataW, 32'h0);
        chk("abort ALUOutW", ALUOutW, 32'h0000_0400);
        chk("abort MemReq", 32'(MemReq), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort MemErrW one cycle", 32'(MemErrW), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
